// File: rtl/game_pkg.sv
// Shared definitions for the target-clicking game: FSM state codes, default
// parameter values, LFSR seed and a small inclusive-range helper.
package game_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_PICK  = 3'd1;
  localparam state_t ST_DRAW  = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_ERASE = 3'd4;
  localparam state_t ST_OVER  = 3'd5;

  localparam int DEF_COORD_W        = 11;
  localparam int DEF_X_MAX          = 639;
  localparam int DEF_Y_MAX          = 479;
  localparam int DEF_SQ_SIZE        = 20;
  localparam int DEF_TIMEOUT_INIT   = 50_000_000;
  localparam int DEF_TIMEOUT_STEP   = 5_000_000;
  localparam int DEF_TIMEOUT_MIN    = 10_000_000;
  localparam int DEF_HITS_PER_LEVEL = 5;
  localparam int DEF_LIVES          = 3;
  localparam int DEF_SCORE_W        = 7;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // True when v lies in [lo, lo+len-1]; 32-bit math so the upper bound cannot wrap.
  function automatic logic in_span(input logic [31:0] v, input logic [31:0] lo,
                                   input logic [31:0] len);
    return (v >= lo) && (v <= lo + len - 32'd1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, one step per clock.
// Maximal-length, so starting from a non-zero seed it never reaches zero.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] out
);

  logic fb;

  assign fb = out[0] ^ out[2] ^ out[3] ^ out[5];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out <= LFSR_SEED;
    else       out <= {fb, out[15:1]};
  end

endmodule

// File: rtl/target_game_ctrl.sv
// Target game controller: places a random square, waits for a click or timeout,
// erases it, tracks score/lives and shortens the timeout every few hits.
module target_game_ctrl
  import game_pkg::*;
#(
  parameter int COORD_W        = DEF_COORD_W,
  parameter int X_MAX          = DEF_X_MAX,
  parameter int Y_MAX          = DEF_Y_MAX,
  parameter int SQ_SIZE        = DEF_SQ_SIZE,
  parameter int TIMEOUT_INIT   = DEF_TIMEOUT_INIT,
  parameter int TIMEOUT_STEP   = DEF_TIMEOUT_STEP,
  parameter int TIMEOUT_MIN    = DEF_TIMEOUT_MIN,
  parameter int HITS_PER_LEVEL = DEF_HITS_PER_LEVEL,
  parameter int LIVES          = DEF_LIVES,
  parameter int SCORE_W        = DEF_SCORE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_game,
  input  logic               click,
  input  logic [COORD_W-1:0] click_x,
  input  logic [COORD_W-1:0] click_y,
  output logic               draw_start,
  output logic [COORD_W-1:0] draw_x0,
  output logic [COORD_W-1:0] draw_y0,
  output logic               draw_color,
  input  logic               draw_done,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               playing,
  output logic               game_over
);

  localparam int TW = $clog2(TIMEOUT_INIT + 1);
  localparam int HW = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

  localparam logic [COORD_W-1:0] X_LIM     = COORD_W'(X_MAX - SQ_SIZE + 1);
  localparam logic [COORD_W-1:0] Y_LIM     = COORD_W'(Y_MAX - SQ_SIZE + 1);
  localparam logic [TW-1:0]      T_INIT    = TW'(TIMEOUT_INIT);
  localparam logic [TW-1:0]      T_STEP    = TW'(TIMEOUT_STEP);
  localparam logic [TW-1:0]      T_MIN     = TW'(TIMEOUT_MIN);
  localparam logic [TW:0]        LIM_FLOOR = (TW+1)'(TIMEOUT_MIN + TIMEOUT_STEP);
  localparam logic [HW-1:0]      HIT_LAST  = HW'(HITS_PER_LEVEL - 1);

  state_t             state;
  logic               pick_y;
  logic [TW-1:0]      timer;
  logic [TW-1:0]      timeout_limit;
  logic [TW-1:0]      next_limit;
  logic [HW-1:0]      hit_cnt;
  logic [15:0]        lfsr;
  logic [COORD_W-1:0] cand;
  logic               hit;
  logic               timed_out;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .out   (lfsr)
  );

  assign cand      = COORD_W'(lfsr);
  assign hit       = click && (state == ST_WAIT) &&
                     in_span(32'(click_x), 32'(draw_x0), 32'(SQ_SIZE)) &&
                     in_span(32'(click_y), 32'(draw_y0), 32'(SQ_SIZE));
  assign timed_out = (timer == timeout_limit - TW'(1));
  assign playing   = (state == ST_PICK) || (state == ST_DRAW) ||
                     (state == ST_WAIT) || (state == ST_ERASE);
  assign game_over = (state == ST_OVER);

  // Step down by TIMEOUT_STEP but never below TIMEOUT_MIN.
  always_comb begin
    next_limit = T_MIN;
    if ({1'b0, timeout_limit} >= LIM_FLOOR) next_limit = timeout_limit - T_STEP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      pick_y        <= 1'b0;
      score         <= '0;
      lives         <= 2'(LIVES);
      draw_start    <= 1'b0;
      draw_color    <= 1'b0;
      draw_x0       <= '0;
      draw_y0       <= '0;
      timer         <= '0;
      timeout_limit <= T_INIT;
      hit_cnt       <= '0;
    end else begin
      draw_start <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start_game) begin
            state         <= ST_PICK;
            pick_y        <= 1'b0;
            score         <= '0;
            lives         <= 2'(LIVES);
            timeout_limit <= T_INIT;
            hit_cnt       <= '0;
          end
        end
        // x and y are drawn from consecutive LFSR values; out-of-range ones retry.
        ST_PICK: begin
          if (!pick_y) begin
            if (cand <= X_LIM) begin
              draw_x0 <= cand;
              pick_y  <= 1'b1;
            end
          end else if (cand <= Y_LIM) begin
            draw_y0    <= cand;
            pick_y     <= 1'b0;
            draw_start <= 1'b1;
            draw_color <= 1'b1;
            state      <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (draw_done) begin
            timer <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          timer <= timer + TW'(1);
          if (hit) begin
            if (score != '1) score <= score + SCORE_W'(1);
            if (hit_cnt == HIT_LAST) begin
              hit_cnt       <= '0;
              timeout_limit <= next_limit;
            end else begin
              hit_cnt <= hit_cnt + HW'(1);
            end
            draw_start <= 1'b1;
            draw_color <= 1'b0;
            state      <= ST_ERASE;
          end else if (timed_out) begin
            lives      <= lives - 2'd1;
            draw_start <= 1'b1;
            draw_color <= 1'b0;
            state      <= ST_ERASE;
          end
        end
        ST_ERASE: begin
          if (draw_done) state <= (lives == 2'd0) ? ST_OVER : ST_PICK;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_target_game_ctrl.sv
// Randomized scoreboard bench for target_game_ctrl: a game-rule model predicts
// each draw/erase request, a monitor pops and compares when draw_start fires.
module tb_target_game_ctrl;

  localparam int CW = 11, XM = 639, YM = 479, SQ = 10;
  localparam int TI = 20, TS = 8, TM = 10, HPL = 2, LV = 3, SW = 7;
  localparam int XLIM = XM - SQ + 1, YLIM = YM - SQ + 1;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 0, reset = 1, start_game = 0, click = 0, draw_done = 0;
  logic [CW-1:0] click_x = '0, click_y = '0;
  logic          draw_start, draw_color, playing, game_over;
  logic [CW-1:0] draw_x0, draw_y0;
  logic [SW-1:0] score;
  logic [1:0]    lives;

  target_game_ctrl #(
    .COORD_W(CW), .X_MAX(XM), .Y_MAX(YM), .SQ_SIZE(SQ), .TIMEOUT_INIT(TI),
    .TIMEOUT_STEP(TS), .TIMEOUT_MIN(TM), .HITS_PER_LEVEL(HPL), .LIVES(LV), .SCORE_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .start_game(start_game), .click(click),
    .click_x(click_x), .click_y(click_y), .draw_start(draw_start),
    .draw_x0(draw_x0), .draw_y0(draw_y0), .draw_color(draw_color),
    .draw_done(draw_done), .score(score), .lives(lives),
    .playing(playing), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int color;
    int score;
    int lives;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_bad = 0;
  int   done_cyc = 0;
  int   m_score, m_lives, m_limit, m_hits;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_and_finish();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  endtask

  task automatic push_exp(input int color, input int sc, input int lv, input int lat);
    exp_t e;
    e.color = color; e.score = sc; e.lives = lv; e.lat = lat;
    sb.push_back(e);
  endtask

  // Monitor: every draw request must match the oldest predicted one.
  int last_x = 0, last_y = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset && draw_start) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_draw_start: got draw_start=1 at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("draw_color", int'(draw_color), e.color);
        chk("score_at_draw", int'(score), e.score);
        chk("lives_at_draw", int'(lives), e.lives);
        if (e.color == 1) begin
          chk("x0_in_range", int'(int'(draw_x0) <= XLIM), 1);
          chk("y0_in_range", int'(int'(draw_y0) <= YLIM), 1);
          last_x = int'(draw_x0);
          last_y = int'(draw_y0);
        end else begin
          chk("erase_x0", int'(draw_x0), last_x);
          chk("erase_y0", int'(draw_y0), last_y);
          chk("wait_latency", cyc - done_cyc, e.lat);
        end
      end
    end
  end

  task automatic wait_ds();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (draw_start) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL draw_start_timeout: got no draw_start, expected one within 3000 cycles");
      report_and_finish();
    end
  endtask

  task automatic start_new();
    m_score = 0; m_lives = LV; m_limit = TI; m_hits = 0;
    push_exp(1, 0, LV, 0);
    start_game = 1;
    @(negedge clk);
    start_game = 0;
    chk("playing_after_start", int'(playing), 1);
    chk("game_over_after_start", int'(game_over), 0);
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      click     = 1'($urandom_range(0, 1));
      click_x   = CW'($urandom_range(0, XM));
      click_y   = CW'($urandom_range(0, YM));
      draw_done = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    click = 0; draw_done = 0;
  endtask

  // mode: 0 hit, 1 miss clicks then timeout, 2 no clicks, <0 random.
  // hit_k: cycle of WAIT on which to hit (-1 random, -2 last cycle). pat: coordinate pattern.
  task automatic play_round(input int mode_in, input int hit_k, input int pat);
    int x0, y0, L, k, endj, d, mode, p, hx, hy;
    wait_ds();
    x0 = int'(draw_x0);
    y0 = int'(draw_y0);
    if ($urandom_range(0, 1) == 1) begin
      click = 1; click_x = CW'(x0); click_y = CW'(y0);
    end
    d = $urandom_range(0, 3);
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      click = 0;
    end
    draw_done = 1;
    done_cyc  = cyc + 1;

    L    = m_limit;
    mode = (mode_in < 0) ? $urandom_range(0, 2) : mode_in;
    k    = 0;
    if (mode == 0) begin
      if (hit_k >= 0)       k = hit_k;
      else if (hit_k == -2) k = L - 1;
      else                  k = ($urandom_range(0, 3) == 0) ? L - 1 : $urandom_range(0, L - 1);
    end
    endj = (mode == 0) ? k + 1 : L;

    if (mode == 0) begin
      if (m_score < SMAX) m_score++;
      m_hits++;
      if (m_hits % HPL == 0) m_limit = (m_limit - TS < TM) ? TM : m_limit - TS;
    end else begin
      m_lives--;
    end
    push_exp(0, m_score, m_lives, endj);

    for (int j = 1; j <= endj; j++) begin
      @(negedge clk);
      draw_done = 0; click = 0; start_game = 0;
      if (mode == 0 && j == endj) begin
        p = (pat >= 0) ? pat : $urandom_range(0, 4);
        case (p)
          0:       begin hx = x0;          hy = y0;          end
          1:       begin hx = x0 + SQ - 1; hy = y0 + SQ - 1; end
          2:       begin hx = x0;          hy = y0 + SQ - 1; end
          3:       begin hx = x0 + SQ - 1; hy = y0;          end
          default: begin hx = x0 + $urandom_range(0, SQ - 1); hy = y0 + $urandom_range(0, SQ - 1); end
        endcase
        click = 1; click_x = CW'(hx); click_y = CW'(hy);
      end else if (mode != 2 && $urandom_range(0, 2) == 0) begin
        p = (mode == 1 && pat >= 0) ? pat : $urandom_range(0, 4);
        case (p)
          0:       begin hx = x0 + SQ; hy = y0;      end
          1:       begin hx = x0;      hy = y0 + SQ; end
          2:       begin hx = (x0 > 0) ? x0 - 1 : x0 + SQ; hy = y0 + SQ - 1; end
          3:       begin hx = x0 + SQ - 1; hy = (y0 > 0) ? y0 - 1 : y0 + SQ; end
          default: begin hx = x0 + SQ + $urandom_range(0, 50); hy = $urandom_range(0, YM); end
        endcase
        click = 1; click_x = CW'(hx); click_y = CW'(hy);
      end else if ($urandom_range(0, 7) == 0) begin
        start_game = 1;
      end else if ($urandom_range(0, 7) == 0) begin
        draw_done = 1;
      end
    end
    @(negedge clk);
    click = 0; start_game = 0; draw_done = 0;

    wait_ds();
    if ($urandom_range(0, 1) == 1) begin
      click = 1; click_x = CW'(x0); click_y = CW'(y0);
    end
    if (m_lives > 0) push_exp(1, m_score, m_lives, 0);
    d = $urandom_range(0, 3);
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      click = 0;
    end
    draw_done = 1;
    @(negedge clk);
    draw_done = 0; click = 0;
    chk("game_over_after_erase", int'(game_over), int'(m_lives == 0));
    chk("playing_after_erase", int'(playing), int'(m_lives != 0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_draw_start"}, int'(draw_start), 0);
    chk({tag, "_draw_color"}, int'(draw_color), 0);
    chk({tag, "_draw_x0"}, int'(draw_x0), 0);
    chk({tag, "_draw_y0"}, int'(draw_y0), 0);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_lives"}, int'(lives), LV);
    chk({tag, "_playing"}, int'(playing), 0);
    chk({tag, "_game_over"}, int'(game_over), 0);
  endtask

  initial begin
    #500_000;
    n_vec++;
    n_bad++;
    $display("FAIL watchdog: got no completion, expected finish within 50000 cycles");
    report_and_finish();
  end

  initial begin
    reset = 1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 0;
    idle_noise(6);
    chk("idle_playing", int'(playing), 0);
    chk("idle_game_over", int'(game_over), 0);

    // Three unanswered targets end the game.
    start_new();
    for (int r = 0; r < 3; r++) play_round(2, -1, -1);
    idle_noise(10);

    // Directed rounds: corner hit, adjacent miss, last-cycle hit, level steps 20->12->10->10.
    start_new();
    play_round(0, 3, 2);
    play_round(1, -1, 0);
    play_round(0, -2, -1);
    play_round(0, -1, -1);
    play_round(0, -1, -1);
    play_round(2, -1, -1);
    play_round(0, -1, -1);
    play_round(0, -2, -1);
    play_round(2, -1, -1);

    for (int g = 0; g < 2; g++) begin
      start_new();
      while (m_lives > 0) play_round(-1, -1, -1);
      idle_noise(5);
    end

    // Long run of hits to reach score saturation.
    start_new();
    for (int r = 0; r < 130; r++) play_round(0, -1, -1);
    while (m_lives > 0) play_round(2, -1, -1);

    // Reset while a square is being drawn.
    start_new();
    play_round(0, -1, -1);
    play_round(2, -1, -1);
    wait_ds();
    #2 reset = 1;
    #1 check_reset_outputs("mid_draw_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    sb.delete();
    idle_noise(40);
    chk("post_reset_playing", int'(playing), 0);
    chk("post_reset_game_over", int'(game_over), 0);

    start_new();
    while (m_lives > 0) play_round(-1, -1, -1);
    idle_noise(5);

    report_and_finish();
  end

endmodule
